// File: rtl/alu_pkg.sv
// Shared ALU writeback definitions: flag bit positions, op codes, writeback entry payload.
package alu_pkg;

  localparam int unsigned ALU_WIDTH  = 32;
  localparam int unsigned ALU_ADDR_W = 4;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;

  localparam logic [3:0] ALU_OP_MAX = OP_MOV;

  typedef struct packed {
    logic [ALU_WIDTH-1:0]  result;
    logic [ALU_ADDR_W-1:0] rd;
  } wb_entry_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer; both handshake outputs come straight from flops.
module wb_skid_buffer #(
  parameter int unsigned DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;

  logic w_push;
  logic w_pop;
  logic w_head_from_in;
  logic w_head_from_tail;
  logic w_tail_load;

  assign w_push = i_valid & r_ready;
  assign w_pop  = r_valid & i_ready;

  // Next state and register-load selects
  always_comb begin
    w_state_nxt      = r_state;
    w_head_from_in   = 1'b0;
    w_head_from_tail = 1'b0;
    w_tail_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt    = ST_ONE;
          w_head_from_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_push && w_pop) begin
          w_head_from_in = 1'b1;
        end else if (w_push) begin
          w_state_nxt = ST_FULL;
          w_tail_load = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_head_from_tail = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_ready <= (w_state_nxt != ST_FULL);
      if (w_head_from_in) begin
        r_head <= i_data;
      end else if (w_head_from_tail) begin
        r_head <= r_tail;
      end
      if (w_tail_load) begin
        r_tail <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_head;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: NZCV commit, illegal-op screening and skid-buffered register-file write.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned ADDR_W = ALU_ADDR_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic [3:0]        in_flags,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_set_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [WIDTH-1:0]  wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [3:0]        status_flags,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic              clr_sticky,
  output logic              sticky_v
`endif
);

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  wb_entry_t        w_in_entry;
  wb_entry_t        w_head;
  logic [ENTRY_W-1:0] w_head_bits;
  logic             w_in_ready;
  logic             w_legal;
  logic             w_accept;
  logic             w_accept_legal;
  logic             w_accept_illegal;

  logic [3:0]       r_status;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  assign w_legal          = is_legal_op(in_op);
  assign w_accept         = in_valid & w_in_ready;
  assign w_accept_legal   = w_accept & w_legal;
  assign w_accept_illegal = w_accept & ~w_legal;

  // Payload widths are fixed by the package; WIDTH/ADDR_W are expected to match them
  assign w_in_entry.result = ALU_WIDTH'(in_result);
  assign w_in_entry.rd     = ALU_ADDR_W'(in_rd);

  wb_skid_buffer #(
    .DATA_W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid & w_legal),
    .o_ready (w_in_ready),
    .i_data  (w_in_entry),
    .o_valid (wb_valid),
    .i_ready (wb_ready),
    .o_data  (w_head_bits)
  );

  assign w_head   = wb_entry_t'(w_head_bits);
  assign wb_data  = WIDTH'(w_head.result);
  assign wb_addr  = ADDR_W'(w_head.rd);
  assign in_ready = w_in_ready;

  // Flags commit in acceptance order; illegal ops are counted but never enqueued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'b0000;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_err <= w_accept_illegal;
      if (w_accept_legal && in_set_flags) begin
        r_status <= in_flags;
      end
      if (w_accept_illegal && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign status_flags = r_status;
  assign err_illegal  = r_err;
  assign illegal_cnt  = r_cnt;

`ifdef ALU_STICKY_OVF_EN
  logic r_sticky;

  // Set has priority over clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_accept_legal && in_set_flags && in_flags[FLAG_V]) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign sticky_v = r_sticky;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (sticky checks when ALU_STICKY_OVF_EN is defined).
module tb_alu_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_op;
  logic [3:0]  in_rd;
  logic        in_set_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_addr;
  logic [3:0]  status_flags;
  logic        err_illegal;
  logic [7:0]  illegal_cnt;
`ifdef ALU_STICKY_OVF_EN
  logic        clr_sticky;
  logic        sticky_v;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  alu_writeback #(
    .WIDTH  (32),
    .ADDR_W (4),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_set_flags (in_set_flags),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_addr      (wb_addr),
    .status_flags (status_flags),
    .err_illegal  (err_illegal),
    .illegal_cnt  (illegal_cnt)
`ifdef ALU_STICKY_OVF_EN
    ,
    .clr_sticky   (clr_sticky),
    .sticky_v     (sticky_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_result = '0; in_flags = '0; in_op = '0; in_rd = '0;
    in_set_flags = 1'b0; wb_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    step();
    step();
    n_checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_addr !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_wb: valid=%b data=%h addr=%h, expected 0/0/0", wb_valid, wb_data, wb_addr);
    end
    n_checks++;
    if (status_flags !== 4'b0000 || err_illegal !== 1'b0 || illegal_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state: flags=%b err=%b cnt=%h, expected 0000/0/00", status_flags, err_illegal, illegal_cnt);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready=%b wb_valid=%b, expected 1/0", in_ready, wb_valid);
    end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_op = 4'd0; in_result = 32'h0000_0005; in_rd = 4'd3;
    in_set_flags = 1'b1; in_flags = 4'b0000; wb_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd5 || wb_addr !== 4'd3 || status_flags !== 4'b0000) begin
      n_errors++;
      $display("FAIL basic_latency: valid=%b data=%h addr=%h flags=%b, expected 1/5/3/0000",
               wb_valid, wb_data, wb_addr, status_flags);
    end
    step();
    n_checks++;
    if (wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_drain: wb_valid=%b, expected 0", wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    in_set_flags = 1'b0; in_op = 4'd2; in_rd = 4'd7; wb_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'd1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ready_one: in_ready=%b, expected 1", in_ready);
    end
    in_result = 32'd2;
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_ready_full: in_ready=%b, expected 0", in_ready);
    end
    in_result = 32'd3;
    step();
    n_checks++;
    if (in_ready !== 1'b0 || wb_data !== 32'd1) begin
      n_errors++;
      $display("FAIL b2b_hold: in_ready=%b wb_data=%h, expected 0/1", in_ready, wb_data);
    end
    wb_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic sent;
      if (wb_valid && wb_ready) got.push_back(wb_data);
      sent = in_valid && in_ready;
      step();
      if (sent) in_valid = 1'b0;
    end
    n_checks++;
    if (got.size() != 3) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d writes, expected 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got[k] !== 32'(k + 1)) begin
          n_errors++;
          $display("FAIL b2b_order[%0d]: got %h, expected %h", k, got[k], k + 1);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flags();
    wb_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd1; in_set_flags = 1'b1; in_flags = 4'b0110; in_result = 32'hA; in_rd = 4'd1;
    step();
    n_checks++;
    if (status_flags !== 4'b0110) begin
      n_errors++;
      $display("FAIL flags_a: status=%b, expected 0110", status_flags);
    end
    in_op = 4'd8; in_set_flags = 1'b0; in_flags = 4'b1111; in_result = 32'hB; in_rd = 4'd0;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (status_flags !== 4'b0110 || wb_data !== 32'hB || wb_addr !== 4'd0) begin
      n_errors++;
      $display("FAIL flags_b: status=%b data=%h addr=%h, expected 0110/b/0", status_flags, wb_data, wb_addr);
    end
    step();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_op = 4'd9; in_set_flags = 1'b1; in_flags = 4'b1111; in_result = 32'hDEAD; in_rd = 4'd2;
    wb_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b0 || err_illegal !== 1'b1 || illegal_cnt !== 8'd1 || status_flags !== 4'b0110) begin
      n_errors++;
      $display("FAIL illegal_one: valid=%b err=%b cnt=%h flags=%b, expected 0/1/01/0110",
               wb_valid, err_illegal, illegal_cnt, status_flags);
    end
    step();
    n_checks++;
    if (err_illegal !== 1'b0 || wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_pulse: err=%b valid=%b, expected 0/0", err_illegal, wb_valid);
    end
    in_valid = 1'b1; in_op = 4'd15;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 100) begin
        n_checks++;
        if (illegal_cnt !== 8'd102) begin
          n_errors++;
          $display("FAIL illegal_mid: cnt=%h, expected 66", illegal_cnt);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (illegal_cnt !== 8'hFF || wb_valid !== 1'b0 || status_flags !== 4'b0110) begin
      n_errors++;
      $display("FAIL illegal_sat: cnt=%h valid=%b flags=%b, expected ff/0/0110", illegal_cnt, wb_valid, status_flags);
    end
    step();
  endtask

  task automatic test_one_state_pass();
    int unsigned q[$];
    in_op = 4'd3; in_set_flags = 1'b0; in_rd = 4'd5;
    wb_ready = 1'b0; in_valid = 1'b1; in_result = 32'd100;
    step();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_result = 32'(101 + i); wb_ready = 1'b1;
      n_checks++;
      if (wb_valid !== 1'b1 || in_ready !== 1'b1 || wb_data !== 32'(100 + i)) begin
        n_errors++;
        $display("FAIL pass_one[%0d]: valid=%b ready=%b data=%0d, expected 1/1/%0d",
                 i, wb_valid, in_ready, wb_data, 100 + i);
      end
      step();
    end
    q.push_back(120);
    for (int k = 0; k < 40; k++) begin
      logic acc;
      in_valid  = 1'($urandom_range(0, 1));
      wb_ready  = 1'($urandom_range(0, 1));
      in_result = 32'(200 + k);
      n_checks++;
      if (in_ready !== (q.size() < 2) || wb_valid !== (q.size() > 0)) begin
        n_errors++;
        $display("FAIL rand_hs[%0d]: ready=%b valid=%b, model depth %0d", k, in_ready, wb_valid, q.size());
      end
      if (wb_valid && wb_ready) begin
        n_checks++;
        if (q.size() == 0 || wb_data !== 32'(q[0])) begin
          n_errors++;
          $display("FAIL rand_order[%0d]: data=%0d, expected %0d", k, wb_data, (q.size() > 0) ? q[0] : 0);
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(200 + k);
      step();
    end
    in_valid = 1'b1; wb_ready = 1'b0; in_result = 32'h5555;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || status_flags !== 4'b0000 || illegal_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL midreset: valid=%b flags=%b cnt=%h, expected 0/0000/00", wb_valid, status_flags, illegal_cnt);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    step();
    n_checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_drop: valid=%b ready=%b, expected 0/1", wb_valid, in_ready);
    end
  endtask

`ifdef ALU_STICKY_OVF_EN
  task automatic test_sticky();
    wb_ready = 1'b1; clr_sticky = 1'b0; in_op = 4'd0; in_rd = 4'd1;
    n_checks++;
    if (sticky_v !== 1'b0) begin
      n_errors++;
      $display("FAIL sticky_reset: sticky=%b, expected 0", sticky_v);
    end
    in_valid = 1'b1; in_set_flags = 1'b1; in_flags = 4'b1000;
    step();
    n_checks++;
    if (sticky_v !== 1'b1) begin
      n_errors++;
      $display("FAIL sticky_set: sticky=%b, expected 1", sticky_v);
    end
    in_flags = 4'b0001;
    step();
    step();
    n_checks++;
    if (sticky_v !== 1'b1 || status_flags !== 4'b0001) begin
      n_errors++;
      $display("FAIL sticky_hold: sticky=%b flags=%b, expected 1/0001", sticky_v, status_flags);
    end
    clr_sticky = 1'b1; in_flags = 4'b1000;
    step();
    n_checks++;
    if (sticky_v !== 1'b1) begin
      n_errors++;
      $display("FAIL sticky_set_wins: sticky=%b, expected 1", sticky_v);
    end
    in_valid = 1'b0;
    step();
    clr_sticky = 1'b0;
    n_checks++;
    if (sticky_v !== 1'b0) begin
      n_errors++;
      $display("FAIL sticky_clear: sticky=%b, expected 0", sticky_v);
    end
    step();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_flags();
    test_illegal();
    test_one_state_pass();
`ifdef ALU_STICKY_OVF_EN
    test_sticky();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Stage directly downstream of the ALU result/flag mux. It captures each ALU result, its 4-bit flag vector and destination register index, and updates the architectural NZCV status register. It then presents the result to the register-file write port through a 2-entry skid buffer with a valid/ready handshake, so ALU issue decouples from register-file stalls. It also screens out illegal ALU select codes.

Parameters:
WIDTH, 32, datapath width; must match the ALU result mux width
ADDR_W, 4, register index width (16 registers)
CNT_W, 8, width of the illegal-op counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU output entry is valid
in_ready  out  1  stage can accept an entry this cycle
in_result  in  WIDTH  ALU result
in_flags  in  4  ALU flags: [0]=N, [1]=C, [2]=Z, [3]=V
in_op  in  4  ALU select code that produced the result; 0-8 legal
in_rd  in  ADDR_W  destination register
in_set_flags  in  1  entry updates the status register
wb_valid  out  1  write request to the register file
wb_ready  in  1  register file accepts the write
wb_data  out  WIDTH  write data
wb_addr  out  ADDR_W  write address
status_flags  out  4  architectural NZCV, same bit order as in_flags
err_illegal  out  1  one-cycle pulse on acceptance of an illegal op
illegal_cnt  out  CNT_W  saturating count of illegal ops

Behaviour:
- Reset (async, rst_n=0): buffer empty, wb_valid=0, wb_data=0, wb_addr=0, in_ready=1 once released, status_flags=4'b0000, err_illegal=0, illegal_cnt=0. If reset asserts mid-stream, all buffered entries are dropped and not written.
- Accept = in_valid & in_ready at a rising edge. Transfer = wb_valid & wb_ready at a rising edge.
- Buffer states: EMPTY (count 0), ONE (count 1), FULL (count 2). in_ready = (state != FULL), derived only from registered state, with no combinational path from wb_ready.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept only -> FULL.
  - ONE + transfer only -> EMPTY.
  - ONE + accept and transfer -> ONE, with the head replaced by the new entry.
  - FULL + transfer -> ONE. No accept is possible in FULL.
- Latency: an entry accepted at edge N drives wb_valid=1 from edge N onward (visible in cycle N+1) when the buffer was empty.
- Order: strict FIFO, and wb_* always shows the head entry.
- wb_data and wb_addr hold stable while wb_valid=1 and wb_ready=0.
- Legal op (in_op <= 8):
  - The entry is enqueued.
  - If in_set_flags=1, status_flags <= in_flags at the accept edge. Flags commit in acceptance order, not at writeback.
- Illegal op (in_op >= 9):
  - Accepted, but not enqueued.
  - No flag update.
  - err_illegal=1 for the following cycle.
  - illegal_cnt increments and saturates at all-ones.
  - Acceptance still requires in_ready=1.
- Illegal accept while a transfer occurs in ONE: state goes ONE -> EMPTY.
- Writes to any address, including 0, are performed. The register file owns any hardwired-zero rule.
- wb_valid is never asserted for an illegal entry.

Optional Feature:
ALU_STICKY_OVF_EN:
- Defined: adds input clr_sticky (1 bit) and output sticky_v (1 bit, reset 0).
- sticky_v sets at any accept edge of a legal, in_set_flags=1 entry with in_flags[3]=1. It clears when clr_sticky=1. Set wins if both happen in the same cycle.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Shared package alu_pkg holds:
  - the flag bit index constants FLAG_N=0, FLAG_C=1, FLAG_Z=2, FLAG_V=3;
  - ALU_OP_MAX=8;
  - the op-code localparams;
  - a packed entry typedef {result, rd}.
- One sub-module, wb_skid_buffer: the generic 2-entry valid/ready buffer parameterised by payload width. alu_writeback instantiates it and owns the flag, illegal-op and sticky logic.

Test Plan:
- Reset, then in_valid=1, in_op=0, in_result=32'h0000_0005, in_rd=3, in_set_flags=1, in_flags=4'b0000, wb_ready=1 -> next cycle wb_valid=1, wb_data=5, wb_addr=3, status_flags=0000.
- Three back-to-back accepts (results 1, 2, 3) with wb_ready=0 -> in_ready=0 after the second accept and the third is held. Then wb_ready=1 -> writes arrive in order 1, 2, 3 with no loss or duplication.
- in_op=4'd9, in_valid=1 -> no wb_valid, err_illegal pulses once, illegal_cnt=1, status_flags unchanged. Apply 300 illegal ops -> illegal_cnt=8'hFF.
- Entry A (set_flags=1, flags=4'b0110), then entry B (set_flags=0, flags=4'b1111) -> status_flags=0110 after A and unchanged after B.
- In ONE state, accept and transfer in the same cycle for 20 cycles, with random wb_ready elsewhere -> state stays ONE and data order is preserved. Assert rst_n=0 mid-stream -> wb_valid=0 immediately, flags=0.
- With ALU_STICKY_OVF_EN: accept a legal entry with V=1 and set_flags=1 -> sticky_v=1, and it persists through later V=0 entries. clr_sticky together with a new V=1 entry -> sticky_v stays 1.
